// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, constants and parity helper
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_DONE
  } ps2_tx_state_e;

  localparam int PS2_FRAME_W         = 11;
  localparam int PS2_INHIBIT_CYC_DEF = 7200;
  localparam int PS2_TIMEOUT_CYC_DEF = 1080000;

  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF pad synchroniser with falling-edge pulse
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic sync,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to 1 (idle bus level) so leaving reset never fakes a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = PS2_INHIBIT_CYC_DEF,
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic [7:0] tx_data_i,
  output logic       busy_o,
  output logic       rx_inhibit_o,
  output logic       done_o,
  output logic       ack_err_o,
  output logic       timeout_o,
  input  logic       ps2_clk_i,
  output logic       ps2_clk_oe_o,
  input  logic       ps2_dat_i,
  output logic       ps2_dat_oe_o
);

  localparam int CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYC);
  localparam logic [3:0]       LAST_BIT = 4'd10;

  ps2_tx_state_e state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [3:0]             bitcnt_q;
  logic [PS2_FRAME_W-1:0] frame_q;
  logic                   ack_err_q;
  logic                   timeout_q;
  logic                   clk_sync, clk_fall;
  logic                   dat_sync, dat_fall_unused;
  logic                   tmo;

  ps2_line_sync u_clk_sync (
    .clk  (clk_i),
    .rst  (rst_i),
    .line (ps2_clk_i),
    .sync (clk_sync),
    .fall (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk  (clk_i),
    .rst  (rst_i),
    .line (ps2_dat_i),
    .sync (dat_sync),
    .fall (dat_fall_unused)
  );

  assign tmo = (state_q inside {ST_SHIFT, ST_ACK, ST_WAIT_IDLE}) && (cnt_q >= TO_LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    tx_ready_o   = 1'b0;
    ps2_clk_oe_o = 1'b0;
    ps2_dat_oe_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_ready_o = 1'b1;
        if (tx_valid_i) state_d = ST_INHIBIT;
      end
      ST_INHIBIT: begin
        ps2_clk_oe_o = 1'b1;
        if (cnt_q >= INH_LAST) state_d = ST_RTS;
      end
      ST_RTS: begin
        ps2_clk_oe_o = 1'b1;
        ps2_dat_oe_o = 1'b1;
        state_d      = ST_SHIFT;
      end
      ST_SHIFT: begin
        // Bit 0 of the frame register is always the bit currently on the wire.
        ps2_dat_oe_o = ~frame_q[0];
        if (tmo)                                   state_d = ST_DONE;
        else if (clk_fall && bitcnt_q == LAST_BIT) state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = tmo ? ST_DONE : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (tmo || (clk_sync && dat_sync)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      frame_q   <= '0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q    <= '0;
          bitcnt_q <= '0;
          if (tx_valid_i) begin
            frame_q   <= {1'b1, ps2_odd_parity(tx_data_i), tx_data_i, 1'b0};
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        ST_INHIBIT: begin
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
        ST_RTS: begin
          cnt_q    <= '0;
          bitcnt_q <= '0;
        end
        ST_SHIFT, ST_ACK, ST_WAIT_IDLE: begin
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          if (tmo) begin
            timeout_q <= 1'b1;
          end else if (state_q == ST_SHIFT) begin
            if (clk_fall && bitcnt_q < LAST_BIT) begin
              frame_q  <= {1'b1, frame_q[PS2_FRAME_W-1:1]};
              bitcnt_q <= bitcnt_q + 4'd1;
            end
          end else if (state_q == ST_ACK) begin
            ack_err_q <= dat_sync;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign rx_inhibit_o = busy_o;
  assign done_o       = (state_q == ST_DONE);
  assign ack_err_o    = done_o & ack_err_q;
  assign timeout_o    = done_o & timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  localparam int H = 20;

  logic clk, rst;
  logic tx_valid, tx_ready, busy, rx_inhibit, done, ack_err, timeout;
  logic [7:0] tx_data;
  logic clk_oe, dat_oe, clk_pad, dat_pad;
  logic dev_clk_low, dev_dat_low, dev_abort;
  int   dev_mode, dev_bit;
  logic [10:0] got;
  int   checks, errors;

  typedef struct packed {
    logic [10:0] frame;
    logic        chk_frame;
    logic        ack_err;
    logic        timeout;
  } exp_t;
  exp_t sb[$];

  assign clk_pad = ~(clk_oe | dev_clk_low);
  assign dat_pad = ~(dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYC(50), .TIMEOUT_CYC(1000)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .tx_data_i    (tx_data),
    .busy_o       (busy),
    .rx_inhibit_o (rx_inhibit),
    .done_o       (done),
    .ack_err_o    (ack_err),
    .timeout_o    (timeout),
    .ps2_clk_i    (clk_pad),
    .ps2_clk_oe_o (clk_oe),
    .ps2_dat_i    (dat_pad),
    .ps2_dat_oe_o (dat_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Device: waits for request-to-send, then clocks 11 falls, samples the
  // host bits in each low phase and optionally acks on the 11th fall.
  initial begin : device_model
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    dev_bit     = 0;
    got         = '0;
    forever begin
      @(negedge clk);
      if (clk_oe && dat_oe) begin
        dev_bit = 0;
        while (clk_oe) @(negedge clk);
        if (dev_mode != 2) begin
          for (int k = 0; k < 11; k++) begin
            repeat (H) @(negedge clk);
            if (dev_abort) break;
            if (k == 0) got[0] = dat_pad;
            if (k == 10 && dev_mode == 0) dev_dat_low = 1'b1;
            dev_clk_low = 1'b1;
            dev_bit     = k + 1;
            repeat (H) @(negedge clk);
            if (k < 10) got[k+1] = dat_pad;
            dev_clk_low = 1'b0;
            if (dev_abort) break;
          end
          repeat (H) @(negedge clk);
          dev_dat_low = 1'b0;
          dev_clk_low = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_err", ack_err, e.ack_err);
        chk("timeout", timeout, e.timeout);
        if (e.chk_frame) chk("frame", got, e.frame);
        chk("clk_oe_at_done", clk_oe, 1'b0);
        chk("dat_oe_at_done", dat_oe, 1'b0);
        chk("rx_inhibit_at_done", rx_inhibit, 1'b1);
      end
    end
  end

  task automatic issue(input logic [7:0] d, input int mode);
    exp_t e;
    int n = 0;
    dev_mode = mode;
    while (!tx_ready && n < 200) begin @(negedge clk); n++; end
    chk("ready_before_issue", tx_ready, 1'b1);
    e.frame     = {1'b1, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
    e.chk_frame = (mode != 2);
    e.ack_err   = (mode == 1);
    e.timeout   = (mode == 2);
    sb.push_back(e);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    chk("clk_oe_after_accept", clk_oe, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    chk("done_seen", done, 1'b1);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input int mode);
    issue(d, mode);
    wait_done(3000);
  endtask

  task automatic wait_shift();
    int n = 0;
    while (!(clk_oe && dat_oe) && n < 200) begin @(negedge clk); n++; end
    chk("rts_seen", clk_oe && dat_oe, 1'b1);
    n = 0;
    while (clk_oe && n < 5) begin @(negedge clk); n++; end
    chk("clk_released", clk_oe, 1'b0);
  endtask

  initial begin : stimulus
    int n;
    logic ready_seen;
    checks = 0; errors = 0;
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0;
    dev_mode = 0; dev_abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_outs", {rx_inhibit, done, ack_err, timeout, clk_oe, dat_oe}, 6'd0);
    rst = 1'b0;
    @(negedge clk);

    send(8'hED, 0);
    send(8'h01, 0);
    send(8'hFF, 0);
    for (int i = 0; i < 4; i++) send(8'($urandom), 0);
    send(8'($urandom), 1);

    issue(8'h3C, 2);
    wait_shift();
    n = 0;
    while (!done && n < 1100) begin @(negedge clk); n++; end
    chk("timeout_latency", n, 1001);
    @(negedge clk);

    issue(8'($urandom), 0);
    wait_shift();
    n = 0;
    while (dev_bit < 4 && n < 2000) begin @(negedge clk); n++; end
    chk("reached_bit4", dev_bit >= 4, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1; dev_abort = 1'b1;
    @(negedge clk);
    chk("midrst_oe", {clk_oe, dat_oe}, 2'b00);
    chk("midrst_ready", tx_ready, 1'b1);
    chk("midrst_done", done, 1'b0);
    sb.delete();
    rst = 1'b0;
    repeat (2 * H + 10) @(negedge clk);
    dev_abort = 1'b0;
    send(8'hF4, 0);

    issue(8'($urandom), 0);
    repeat (5) @(negedge clk);
    chk("inhibit_pads", {clk_oe, dat_oe}, 2'b10);
    tx_valid = 1'b1; tx_data = 8'h55;
    @(negedge clk);
    tx_valid = 1'b0;
    ready_seen = 1'b0;
    n = 0;
    while (!done && n < 3000) begin ready_seen |= tx_ready; @(negedge clk); n++; end
    ready_seen |= tx_ready;
    chk("done_after_ignored", done, 1'b1);
    chk("ready_low_while_busy", ready_seen, 1'b0);
    repeat (20) @(negedge clk);
    chk("second_byte_ignored", busy, 1'b0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: it sends a command byte (for example LED set 0xED or reset 0xFF) from the SoC to an attached keyboard or mouse over the open-drain PS/2 clock and data pads. It sits next to the existing PS/2 receiver inside the peripheral subsystem and shares the same pads through open-drain enables. It performs request-to-send, bit shifting on device-generated clocks, odd parity, stop, acknowledge check and timeout. While it owns the bus, it holds the receiver off.

## Interface
Parameters:
- `INHIBIT_CYC`, default 7200: clock-low inhibit length in `clk_i` cycles (100 us at 72 MHz).
- `TIMEOUT_CYC`, default 1080000: maximum cycles from clock release to bus-idle after ack (15 ms at 72 MHz).

Ports:
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `tx_valid_i`  in  1  byte request.
- `tx_ready_o`  out  1  high only in IDLE; a transfer is accepted on `tx_valid_i & tx_ready_o`.
- `tx_data_i`  in  8  command byte, captured at accept.
- `busy_o`  out  1  high in every state except IDLE.
- `rx_inhibit_o`  out  1  equals `busy_o`; the receiver ignores the bus while it is high.
- `done_o`  out  1  one-cycle pulse at the end of every transfer.
- `ack_err_o`  out  1  one-cycle pulse coincident with `done_o`; the device did not pull data low at ack.
- `timeout_o`  out  1  one-cycle pulse coincident with `done_o`; `TIMEOUT_CYC` expired.
- `ps2_clk_i`  in  1  clock pad input, asynchronous.
- `ps2_clk_oe_o`  out  1  1 = drive clock pad low, 0 = release.
- `ps2_dat_i`  in  1  data pad input, asynchronous.
- `ps2_dat_oe_o`  out  1  1 = drive data pad low, 0 = release.

## Operation
- Both pad inputs pass through 2-FF synchronisers. A clock falling-edge pulse `fall` is asserted when the synchronised clock is 0 and its previous value was 1.
- Frame to send: {stop=1, parity=~^data, data[7:0]}, shifted LSB first after the start bit (0).
- States and transitions:
  - IDLE: `tx_ready_o`=1. Accept captures the frame → INHIBIT.
  - INHIBIT: `clk_oe`=1, `dat_oe`=0. Counts `INHIBIT_CYC` cycles → RTS.
  - RTS: `clk_oe`=1, `dat_oe`=1 for exactly 1 cycle → SHIFT. The timeout counter clears here.
  - SHIFT: `clk_oe`=0, `dat_oe`=1 (start bit). On each `fall` with `bitcnt` 0..9, `dat_oe` takes the complement of frame bit `bitcnt`, then `bitcnt`++. Fall 10 drives the stop bit, which means release. The next `fall` (the 11th) → ACK handling.
  - ACK: on the 11th `fall`, sample synchronised data; a high sample sets the `ack_err` flag → WAIT_IDLE.
  - WAIT_IDLE: both lines released. When synchronised clock and data are both 1 → DONE.
  - DONE: `done_o`=1 together with the flag pulses → IDLE.
- Timeout: in SHIFT, ACK or WAIT_IDLE, the counter reaching `TIMEOUT_CYC` releases both lines → DONE with `timeout_o`=1. Timeout takes priority over a same-cycle `fall`.
- `tx_valid_i` is ignored while busy. `tx_data_i` is don't-care except at accept.
- `bitcnt` is 4 bits and is never allowed past 10. The cycle counter is `$clog2(max(INHIBIT_CYC,TIMEOUT_CYC)+1)` bits and saturates.

## Timing
- Reset values: `tx_ready_o`=1; every other output is 0. State is IDLE and all counters are 0.
- `rst_i` asserted mid-transfer: the next edge releases both pads and returns to IDLE. No `done_o` is produced.
- Accept at edge N: `ps2_clk_oe_o`=1 from N+1, held for `INHIBIT_CYC` cycles, then 1 RTS cycle, then clock released.
- Pad falling edge to `ps2_dat_oe_o` update: 3 `clk_i` cycles (2 sync + 1 register). This is well inside the device's ~30 us low phase.
- `done_o` rises 1 cycle after the bus-idle or timeout condition. `tx_ready_o` rises the following cycle.
- Back-to-back: `tx_valid_i` held high is accepted in the first IDLE cycle after DONE.

## Structure
- `ps2_pkg`:
  - the state enum;
  - `ps2_odd_parity(logic [7:0])` function;
  - frame width constant (11);
  - default timing constants.
  - The receiver reuses the parity function.
- Sub-module `ps2_line_sync`: 2-FF synchroniser plus previous-value register with a fall-pulse output, instantiated for both clock and data.
- The top level holds the FSM, the 11-bit frame shift register and the counters.

## Test plan
- Send 0xED to a device model clocking at 12.5 kHz that acks → data line after the start bit reads 1,0,1,1,0,1,1,1, parity 1, stop 1. `done_o`=1, `ack_err_o`=0, `timeout_o`=0.
- Send 0x01 → parity bit 0. Send 0xFF → parity bit 1. Both are acked and complete.
- Device model omits the ack (data high at fall 11) → `done_o` and `ack_err_o` pulse together. Both `oe` outputs are 0.
- Device model never clocks, with `TIMEOUT_CYC`=1000 → `timeout_o` with `done_o` exactly 1001 cycles after the RTS→SHIFT transition. Pads are released.
- Assert `rst_i` during bit 4 → the next cycle both `oe`=0, `tx_ready_o`=1, and no `done_o`. A new 0xF4 transfer then completes normally.
- Pulse `tx_valid_i` during INHIBIT with 0x55 → ignored. Only the first byte is transmitted. `tx_ready_o` stays 0 until DONE.
